bus_to_bb_addr_bridge: RTL and testbench



---
 rtl/bus_to_bb_addr_bridge.sv | 140 ++++++++++++++
 tb/tb_bus_to_bb_addr_bridge.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/bus_to_bb_addr_bridge.sv
// Bus-to-BB address bridge.
// Takes system-bus requests, checks that the 16-bit bus address has a BB
// equivalent, folds it down to the 12-bit BB address and queues the result
// in a small FIFO for the board-bridge transmit logic. Requests whose address
// has no BB equivalent are dropped and reported on the error outputs.
module bus_to_bb_addr_bridge #(
  parameter int BB_ADDR_WIDTH      = 12,
  parameter int BUS_ADDR_WIDTH     = 16,
  parameter int BUS_MEM_ADDR_WIDTH = 12,
  parameter int DATA_WIDTH         = 8,
  parameter int FIFO_DEPTH         = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [BUS_ADDR_WIDTH-1:0] in_addr,
  input  logic [DATA_WIDTH-1:0]     in_data,
  input  logic                      in_wr,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [BB_ADDR_WIDTH-1:0]  out_addr,
  output logic [DATA_WIDTH-1:0]     out_data,
  output logic                      out_wr,
  output logic                      err_pulse,
  output logic [BUS_ADDR_WIDTH-1:0] err_addr,
  output logic [7:0]                err_count
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

  typedef struct packed {
    logic [BB_ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0]    data;
    logic                     wr;
  } entry_t;

  entry_t                    mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]          wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]          rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]          count_q, count_d;
  logic                      err_pulse_q, err_pulse_d;
  logic [BUS_ADDR_WIDTH-1:0] err_addr_q, err_addr_d;
  logic [7:0]                err_count_q, err_count_d;

  logic   addr_legal;
  entry_t in_entry;
  logic   accept;
  logic   push;
  logic   pop;
  logic   err_hit;

  // Address legality check and bus-to-BB conversion, done before the FIFO.
  always_comb begin
    in_entry = '0;
    addr_legal = (in_addr[BUS_MEM_ADDR_WIDTH-1:BB_ADDR_WIDTH-1] == '0) &&
                 (in_addr[BUS_ADDR_WIDTH-1:BUS_MEM_ADDR_WIDTH+1] == '0);
    in_entry.addr = {in_addr[BUS_MEM_ADDR_WIDTH], in_addr[BB_ADDR_WIDTH-2:0]};
    in_entry.data = in_data;
    in_entry.wr   = in_wr;
  end

  // Handshake decode; in_ready depends only on reset and registered occupancy.
  always_comb begin
    in_ready  = !rst && (count_q < CNT_W'(FIFO_DEPTH));
    out_valid = (count_q != '0);
    accept    = in_valid && in_ready;
    push      = accept && addr_legal;
    err_hit   = accept && !addr_legal;
    pop       = out_valid && out_ready;
  end

  // Next-state for FIFO pointers, occupancy and error reporting.
  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    err_pulse_d = err_hit;
    err_addr_d  = err_addr_q;
    err_count_d = err_count_q;
    if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
    if (err_hit) begin
      err_addr_d = in_addr;
      if (err_count_q != 8'hFF) err_count_d = err_count_q + 8'd1;
    end
  end

  // Control state register with synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values regardless of block evaluation order.
    if (rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      err_pulse_q <= 1'b0;
      err_addr_q  <= '0;
      err_count_q <= '0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      err_pulse_q <= err_pulse_d;
      err_addr_q  <= err_addr_d;
      err_count_q <= err_count_d;
    end
  end

  // FIFO storage write port.
  always_ff @(posedge clk) begin
    // NOTE: the storage array is deliberately not reset; occupancy is, and the
    // output fields are masked while the FIFO is empty, so stale entries are
    // never visible.
    if (push) mem_q[wr_ptr_q] <= in_entry;
  end

  // Present the FIFO head, forced to zero while empty.
  always_comb begin
    out_addr = '0;
    out_data = '0;
    out_wr   = 1'b0;
    if (out_valid) begin
      out_addr = mem_q[rd_ptr_q].addr;
      out_data = mem_q[rd_ptr_q].data;
      out_wr   = mem_q[rd_ptr_q].wr;
    end
  end

  assign err_pulse = err_pulse_q;
  assign err_addr  = err_addr_q;
  assign err_count = err_count_q;

endmodule

// File: tb/tb_bus_to_bb_addr_bridge.sv
// Self-checking bench for bus_to_bb_addr_bridge: a queue-based reference
// model checked every cycle, plus directed vectors with literal expectations.
module tb_bus_to_bb_addr_bridge;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_addr;
  logic [7:0]  in_data;
  logic        in_wr;
  logic        out_valid;
  logic        out_ready;
  logic [11:0] out_addr;
  logic [7:0]  out_data;
  logic        out_wr;
  logic        err_pulse;
  logic [15:0] err_addr;
  logic [7:0]  err_count;

  int n_cmp  = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  bus_to_bb_addr_bridge dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_addr   (in_addr),
    .in_data   (in_data),
    .in_wr     (in_wr),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_addr  (out_addr),
    .out_data  (out_data),
    .out_wr    (out_wr),
    .err_pulse (err_pulse),
    .err_addr  (err_addr),
    .err_count (err_count)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    int addr;
    int data;
    int wr;
  } req_t;

  req_t m_q[$];
  int   m_err_pulse = 0;
  int   m_err_addr  = 0;
  int   m_err_count = 0;

  function automatic bit m_legal(input int a);
    // Legal only when bit 11 and bits 15..13 are all clear.
    return ((a / 2048) % 2 == 0) && (a / 8192 == 0);
  endfunction

  function automatic int m_convert(input int a);
    // Bus bit 12 moves down to BB bit 11; the low 11 bits pass through.
    return ((a / 4096) % 2) * 2048 + (a % 2048);
  endfunction

  always @(posedge clk) begin
    bit ready;
    bit acc;
    ready = !rst && (m_q.size() < 2);
    acc   = in_valid && ready;
    if (rst) begin
      m_q.delete();
      m_err_pulse = 0;
      m_err_addr  = 0;
      m_err_count = 0;
    end else begin
      if (m_q.size() != 0 && out_ready) void'(m_q.pop_front());
      m_err_pulse = 0;
      if (acc) begin
        if (m_legal(int'(in_addr))) begin
          req_t r;
          r.addr = m_convert(int'(in_addr));
          r.data = int'(in_data);
          r.wr   = int'(in_wr);
          m_q.push_back(r);
        end else begin
          m_err_pulse = 1;
          m_err_addr  = int'(in_addr);
          if (m_err_count < 255) m_err_count++;
        end
      end
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      check("in_ready",  32'(in_ready),  32'(!rst && (m_q.size() < 2)));
      check("out_valid", 32'(out_valid), 32'(m_q.size() != 0));
      if (m_q.size() != 0) begin
        check("out_addr", 32'(out_addr), 32'(m_q[0].addr));
        check("out_data", 32'(out_data), 32'(m_q[0].data));
        check("out_wr",   32'(out_wr),   32'(m_q[0].wr));
      end else begin
        check("out_addr_idle", 32'(out_addr), 32'd0);
      end
      check("err_pulse", 32'(err_pulse), 32'(m_err_pulse));
      check("err_addr",  32'(err_addr),  32'(m_err_addr));
      check("err_count", 32'(err_count), 32'(m_err_count));
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic req(input logic v, input logic [15:0] a, input logic [7:0] d, input logic w);
    in_valid = v;
    in_addr  = a;
    in_data  = d;
    in_wr    = w;
  endtask

  initial begin
    rst = 1'b1;
    out_ready = 1'b0;
    req(1'b0, 16'h0, 8'h0, 1'b0);
    step();
    chk_en = 1'b1;
    step();
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_err_count", 32'(err_count), 32'd0);

    // Leave reset: ready immediately.
    rst = 1'b0;
    #1;
    check("post_rst_in_ready", 32'(in_ready), 32'd1);

    // Basic write conversion.
    out_ready = 1'b1;
    req(1'b1, 16'h1123, 8'hA5, 1'b1);
    step();
    req(1'b0, 16'h0, 8'h0, 1'b0);
    check("w1_valid", 32'(out_valid), 32'd1);
    check("w1_addr",  32'(out_addr),  32'h923);
    check("w1_data",  32'(out_data),  32'hA5);
    check("w1_wr",    32'(out_wr),    32'd1);
    step();
    check("w1_popped", 32'(out_valid), 32'd0);

    // Read, then max legal address pushed while the first pops.
    req(1'b1, 16'h0456, 8'h3C, 1'b0);
    step();
    check("r_addr", 32'(out_addr), 32'h456);
    check("r_wr",   32'(out_wr),   32'd0);
    req(1'b1, 16'h17FF, 8'h11, 1'b1);
    step();
    req(1'b0, 16'h0, 8'h0, 1'b0);
    check("max_addr", 32'(out_addr), 32'hFFF);
    step();

    // Two illegal addresses.
    req(1'b1, 16'h0800, 8'h00, 1'b1);
    step();
    check("e1_pulse", 32'(err_pulse), 32'd1);
    check("e1_addr",  32'(err_addr),  32'h0800);
    check("e1_valid", 32'(out_valid), 32'd0);
    req(1'b1, 16'h2000, 8'h00, 1'b0);
    step();
    req(1'b0, 16'h0, 8'h0, 1'b0);
    check("e2_pulse", 32'(err_pulse), 32'd1);
    check("e2_addr",  32'(err_addr),  32'h2000);
    check("e2_count", 32'(err_count), 32'd2);
    step();
    check("e_pulse_clear", 32'(err_pulse), 32'd0);

    // Fill with back-pressure, third request held off.
    out_ready = 1'b0;
    req(1'b1, 16'h0001, 8'h01, 1'b1);
    step();
    req(1'b1, 16'h0002, 8'h02, 1'b1);
    step();
    check("full_ready", 32'(in_ready), 32'd0);
    req(1'b1, 16'h0003, 8'h03, 1'b1);
    step();
    step();
    check("full_hold_addr", 32'(out_addr), 32'h001);
    req(1'b0, 16'h0, 8'h0, 1'b0);
    out_ready = 1'b1;
    step();
    check("drain2_addr",  32'(out_addr), 32'h002);
    check("drain_ready",  32'(in_ready), 32'd1);
    step();
    check("drain_empty", 32'(out_valid), 32'd0);

    // Steady push+pop at count=1.
    for (int i = 0; i < 10; i++) begin
      req(1'b1, 16'(16'h1000 + i), 8'(i), 1'b0);
      step();
      check("stream_addr", 32'(out_addr), 32'(12'h800 + i));
      check("stream_valid", 32'(out_valid), 32'd1);
    end
    req(1'b0, 16'h0, 8'h0, 1'b0);
    step();
    check("stream_empty", 32'(out_valid), 32'd0);

    // Saturate the error counter.
    for (int i = 0; i < 300; i++) begin
      req(1'b1, 16'(16'h8000 + i), 8'h00, 1'b0);
      step();
    end
    req(1'b0, 16'h0, 8'h0, 1'b0);
    check("err_sat", 32'(err_count), 32'd255);

    // Buffer two entries, then reset mid-operation.
    out_ready = 1'b0;
    req(1'b1, 16'h0005, 8'h55, 1'b1);
    step();
    req(1'b1, 16'h0006, 8'h66, 1'b1);
    step();
    check("pre_rst_valid", 32'(out_valid), 32'd1);
    rst = 1'b1;
    req(1'b1, 16'h0007, 8'h77, 1'b1);
    out_ready = 1'b1;
    step();
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_errcnt", 32'(err_count), 32'd0);
    check("rst_ready", 32'(in_ready), 32'd0);
    rst = 1'b0;
    req(1'b0, 16'h0, 8'h0, 1'b0);
    step();
    check("no_stale", 32'(out_valid), 32'd0);
    req(1'b1, 16'h0009, 8'h99, 1'b0);
    step();
    req(1'b0, 16'h0, 8'h0, 1'b0);
    check("fresh_addr", 32'(out_addr), 32'h009);
    check("fresh_data", 32'(out_data), 32'h99);
    step();
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
